l1_d_ctrl: RTL and testbench

L1_D_CTRL -- requirements
Module: l1_d_ctrl

---
 rtl/l1_d_ctrl.sv | 143 ++++++++++++++
 tb/tb_l1_d_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/l1_d_ctrl.sv
// Two-way set-associative L1 data-cache controller: tag/valid/dirty/LRU state,
// hit/miss FSM and the L2 write-back / refill handshake for an external data array.
module l1_d_ctrl #(
    parameter int TNUM = 24,
    parameter int INUM = 26 - TNUM,
    parameter int WAY  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_C_L1,
    input  logic            we_C_L1,
    input  logic [31:0]     addr_C_L1,
    output logic            ready_L1_C,
    output logic [INUM-1:0] index_C_L1,
    output logic [5:0]      offset,
    output logic            way,
    output logic            refill,
    output logic            update,
    output logic            read_L1_L2,
    output logic            write_L1_L2,
    output logic [25:0]     addr_L1_L2,
    input  logic            ready_L2_L1
);
    localparam int SETS = 1 << INUM;

    typedef enum logic [2:0] {IDLE, COMPARE, HIT, WRITEBACK, ALLOCATE} state_t;

    state_t          state_q;
    logic [TNUM-1:0] tag_q [SETS][WAY];
    logic [WAY-1:0]  valid_q [SETS];
    logic [WAY-1:0]  dirty_q [SETS];
    logic [SETS-1:0] lru_q;

    logic [TNUM-1:0] req_tag_q;
    logic            we_q;
    logic [INUM-1:0] index_q;
    logic [5:0]      offset_q;
    logic            way_q;
    logic            ready_q;
    logic            update_q;
    logic            read_q;
    logic            write_q;
    logic [25:0]     addr_q;

    logic hit0, hit1, hit, victim, sel_way;

    assign hit0    = valid_q[index_q][0] && (tag_q[index_q][0] == req_tag_q);
    assign hit1    = valid_q[index_q][1] && (tag_q[index_q][1] == req_tag_q);
    assign hit     = hit0 || hit1;
    assign victim  = !valid_q[index_q][0] ? 1'b0 :
                     !valid_q[index_q][1] ? 1'b1 : lru_q[index_q];
    assign sel_way = hit ? hit1 : victim;

    // Way is resolved combinationally in COMPARE so the array read lines up with HIT.
    assign way         = (state_q == COMPARE) ? sel_way : way_q;
    assign refill      = (state_q == ALLOCATE) && read_q && ready_L2_L1 && !rst;
    assign ready_L1_C  = ready_q;
    assign update      = update_q;
    assign read_L1_L2  = read_q;
    assign write_L1_L2 = write_q;
    assign addr_L1_L2  = addr_q;
    assign index_C_L1  = index_q;
    assign offset      = offset_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            lru_q     <= '0;
            req_tag_q <= '0;
            we_q      <= 1'b0;
            index_q   <= '0;
            offset_q  <= '0;
            way_q     <= 1'b0;
            ready_q   <= 1'b0;
            update_q  <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
        end else begin
            ready_q  <= 1'b0;
            update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_C_L1) begin
                        req_tag_q <= addr_C_L1[31 -: TNUM];
                        index_q   <= addr_C_L1[6 +: INUM];
                        offset_q  <= addr_C_L1[5:0];
                        we_q      <= we_C_L1;
                        state_q   <= COMPARE;
                    end
                end
                COMPARE: begin
                    way_q <= sel_way;
                    if (hit) begin
                        ready_q  <= 1'b1;
                        update_q <= we_q;
                        state_q  <= HIT;
                    end else if (valid_q[index_q][victim] && dirty_q[index_q][victim]) begin
                        write_q <= 1'b1;
                        addr_q  <= {tag_q[index_q][victim], index_q};
                        state_q <= WRITEBACK;
                    end else begin
                        read_q  <= 1'b1;
                        addr_q  <= {req_tag_q, index_q};
                        state_q <= ALLOCATE;
                    end
                end
                HIT: begin
                    if (we_q) dirty_q[index_q][way_q] <= 1'b1;
                    lru_q[index_q] <= ~way_q;
                    state_q        <= IDLE;
                end
                WRITEBACK: begin
                    if (ready_L2_L1) begin
                        dirty_q[index_q][way_q] <= 1'b0;
                        write_q <= 1'b0;
                        read_q  <= 1'b1;
                        addr_q  <= {req_tag_q, index_q};
                        state_q <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    // read_q low marks the settle cycle after the line has been written.
                    if (read_q) begin
                        if (ready_L2_L1) begin
                            read_q                  <= 1'b0;
                            tag_q[index_q][way_q]   <= req_tag_q;
                            valid_q[index_q][way_q] <= 1'b1;
                            dirty_q[index_q][way_q] <= 1'b0;
                        end
                    end else begin
                        state_q <= COMPARE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_d_ctrl.sv
// Directed bench for l1_d_ctrl: transaction table with hand-computed timing,
// addresses and data, plus reset and stray-handshake sequences.
module tb_l1_d_ctrl;
    logic        clk = 1'b0;
    logic        rst, req, we, l2_rdy;
    logic [31:0] addr, wdata;
    logic        ready_L1_C, way, refill, update, read_L1_L2, write_L1_L2;
    logic [1:0]  index_C_L1;
    logic [5:0]  offset;
    logic [25:0] addr_L1_L2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    l1_d_ctrl dut (
        .clk(clk), .rst(rst), .req_C_L1(req), .we_C_L1(we), .addr_C_L1(addr),
        .ready_L1_C(ready_L1_C), .index_C_L1(index_C_L1), .offset(offset), .way(way),
        .refill(refill), .update(update), .read_L1_L2(read_L1_L2),
        .write_L1_L2(write_L1_L2), .addr_L1_L2(addr_L1_L2), .ready_L2_L1(l2_rdy)
    );

    // Data array: 1-cycle read; refilled words are {line address, word number}.
    logic [31:0] dmem [128];
    logic [31:0] rdata_q;
    always @(posedge clk) begin
        rdata_q <= dmem[{index_C_L1, way, offset[5:2]}];
        if (update) dmem[{index_C_L1, way, offset[5:2]}] <= wdata;
        if (refill)
            for (int w = 0; w < 16; w++) dmem[{index_C_L1, way, w[3:0]}] <= {addr_L1_L2, w[5:0]};
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_rdy;
        int          exp_wr;
        logic [25:0] exp_wb_addr;
        int          exp_rd;
        logic [25:0] exp_rd_addr;
        logic        exp_way;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[18];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        int t_rdy, t_wr, t_rd, t_ref, n_ref, n_upd, n_wrc, n_rdc, n_viol, l2_start;
        logic [25:0] wba, rda;
        logic wy;
        logic [31:0] rd;
        v = vecs[i];
        t_rdy = -1; t_wr = -1; t_rd = -1; t_ref = -1; l2_start = -1;
        n_ref = 0; n_upd = 0; n_wrc = 0; n_rdc = 0; n_viol = 0;
        wba = '0; rda = '0; wy = 1'b0; rd = '0;
        @(posedge clk); #1;
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; l2_rdy = 1'b0;
        for (int cyc = 0; cyc < 100 && t_rdy < 0; cyc++) begin
            @(negedge clk);
            if (write_L1_L2) begin n_wrc++; if (t_wr < 0) begin t_wr = cyc; wba = addr_L1_L2; end end
            if (read_L1_L2) begin n_rdc++; if (t_rd < 0) begin t_rd = cyc; rda = addr_L1_L2; end end
            if (refill) begin n_ref++; t_ref = cyc; end
            if (update) n_upd++;
            if ((read_L1_L2 && write_L1_L2) || (refill && update)) n_viol++;
            if (ready_L1_C) begin t_rdy = cyc; wy = way; rd = rdata_q; end
            if (l2_rdy) l2_start = -1;
            else if ((read_L1_L2 || write_L1_L2) && l2_start < 0) l2_start = cyc;
            @(posedge clk); #1;
            l2_rdy = (l2_start >= 0) && (cyc + 1 == l2_start + v.lat);
            if (t_rdy >= 0) req = 1'b0;
        end
        req = 1'b0;
        l2_rdy = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_rdy_pulse", i), ready_L1_C, 1'b0);
        chk($sformatf("v%0d_rdy_cycle", i), t_rdy, v.exp_rdy);
        chk($sformatf("v%0d_wr_cycle", i), t_wr, v.exp_wr);
        chk($sformatf("v%0d_rd_cycle", i), t_rd, v.exp_rd);
        if (v.exp_wr >= 0) chk($sformatf("v%0d_wb_addr", i), wba, v.exp_wb_addr);
        if (v.exp_rd >= 0) chk($sformatf("v%0d_rd_addr", i), rda, v.exp_rd_addr);
        chk($sformatf("v%0d_wr_len", i), n_wrc, (v.exp_wr >= 0) ? v.lat + 1 : 0);
        chk($sformatf("v%0d_rd_len", i), n_rdc, (v.exp_rd >= 0) ? v.lat + 1 : 0);
        chk($sformatf("v%0d_refill_cycle", i), t_ref, (v.exp_rd >= 0) ? v.exp_rd + v.lat : -1);
        chk($sformatf("v%0d_refill_cnt", i), n_ref, (v.exp_rd >= 0) ? 1 : 0);
        chk($sformatf("v%0d_update_cnt", i), n_upd, v.we ? 1 : 0);
        chk($sformatf("v%0d_way", i), wy, v.exp_way);
        chk($sformatf("v%0d_overlap", i), n_viol, 0);
        if (v.chk_data) chk($sformatf("v%0d_data", i), rd, v.exp_data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        logic seen;
        // we, addr, wdata, lat, rdy, wr, wb_addr, rd, rd_addr, way, chk_data, data
        vecs[0]  = '{1'b0, 32'h104, 32'h0,        4, 9,  -1, 26'h0, 2,  26'h4,  1'b0, 1'b1, 32'h101};
        vecs[1]  = '{1'b0, 32'h108, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b0, 1'b1, 32'h102};
        vecs[2]  = '{1'b1, 32'h108, 32'hDEADBEEF, 0, 2,  -1, 26'h0, -1, 26'h0,  1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h108, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b0, 1'b1, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 32'h204, 32'h0,        2, 7,  -1, 26'h0, 2,  26'h8,  1'b1, 1'b1, 32'h201};
        vecs[5]  = '{1'b0, 32'h104, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b0, 1'b1, 32'h101};
        vecs[6]  = '{1'b0, 32'h200, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b1, 1'b1, 32'h200};
        vecs[7]  = '{1'b0, 32'h300, 32'h0,        3, 12, 2,  26'h4, 6,  26'hC,  1'b0, 1'b1, 32'h300};
        vecs[8]  = '{1'b0, 32'h204, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b1, 1'b1, 32'h201};
        vecs[9]  = '{1'b0, 32'h304, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b0, 1'b1, 32'h301};
        vecs[10] = '{1'b0, 32'h208, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b1, 1'b1, 32'h202};
        vecs[11] = '{1'b0, 32'h400, 32'h0,        1, 6,  -1, 26'h0, 2,  26'h10, 1'b0, 1'b1, 32'h400};
        vecs[12] = '{1'b0, 32'h200, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b1, 1'b1, 32'h200};
        vecs[13] = '{1'b0, 32'h20C, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b1, 1'b1, 32'h203};
        vecs[14] = '{1'b0, 32'h500, 32'h0,        2, 7,  -1, 26'h0, 2,  26'h14, 1'b0, 1'b1, 32'h500};
        vecs[15] = '{1'b1, 32'h048, 32'hCAFEF00D, 1, 6,  -1, 26'h0, 2,  26'h1,  1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h048, 32'h0,        0, 2,  -1, 26'h0, -1, 26'h0,  1'b0, 1'b1, 32'hCAFEF00D};
        vecs[17] = '{1'b0, 32'h600, 32'h0,        2, 7,  -1, 26'h0, 2,  26'h18, 1'b0, 1'b1, 32'h600};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; l2_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_L1_C, 1'b0);
        chk("rst_refill", refill, 1'b0);
        chk("rst_update", update, 1'b0);
        chk("rst_read", read_L1_L2, 1'b0);
        chk("rst_write", write_L1_L2, 1'b0);
        chk("rst_index", index_C_L1, 2'd0);
        chk("rst_offset", offset, 6'd0);
        chk("rst_way", way, 1'b0);
        chk("rst_addr_l2", addr_L1_L2, 26'd0);

        // A stray L2 completion while idle must have no effect.
        @(posedge clk); #1 l2_rdy = 1'b1;
        @(negedge clk);
        chk("idle_l2rdy_refill", refill, 1'b0);
        chk("idle_l2rdy_ready", ready_L1_C, 1'b0);
        @(posedge clk); #1 l2_rdy = 1'b0;

        for (int i = 0; i < 17; i++) run_vec(i);

        // Reset while a line fetch is outstanding.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h600;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (read_L1_L2) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("rstalloc_read_seen", seen, 1'b1);
        @(posedge clk); #1 rst = 1'b1; req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstalloc_read", read_L1_L2, 1'b0);
        chk("rstalloc_write", write_L1_L2, 1'b0);
        chk("rstalloc_addr_l2", addr_L1_L2, 26'd0);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1 l2_rdy = (c == 0);
            @(negedge clk);
            if (refill || ready_L1_C || read_L1_L2 || update) bad++;
        end
        l2_rdy = 1'b0;
        chk("rstalloc_quiet", bad, 0);

        run_vec(17);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
